id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, sitting directly upstream of ALU control and the ALU.
- Latches the decoded instruction and control bits, and resolves EX/MEM and MEM/WB forwarding.
- Drives the final ALU operands x/y plus opcode/funct/ALUOp to ALU control.
- Detects load-use hazards and inserts a bubble itself.

Parameters:
- DW, 32, datapath width
- RW, 5, register-index width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hold current EX contents (downstream stall)
- flush_i  in  1  squash instruction entering EX (branch/jump redirect)
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  sign/zero-extended immediate
- id_shamt  in  5  shift amount
- id_rs, id_rt, id_rd  in  RW  register indices
- id_opcode, id_funct  in  6  instruction fields
- id_aluop  in  2  10=R-type, 01=I-type, 00=none
- id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  decoded controls
- exmem_regwrite  in  1  EX/MEM writes back
- exmem_rd  in  RW  EX/MEM destination
- exmem_result  in  DW  EX/MEM ALU result
- memwb_regwrite  in  1  MEM/WB writes back
- memwb_rd  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB writeback value
- load_use_o  out  1  combinational; upstream must hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_opcode, ex_funct  out  6  to ALU control
- ex_aluop  out  2  to ALU control
- alu_x, alu_y  out  DW  ALU operands, combinational from EX regs plus forwarding
- ex_store_data  out  DW  forwarded rt value for SW
- ex_dest  out  RW  writeback index
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  to EX/MEM

Behaviour:
- Reset: all EX registers clear to 0 on the rst edge. ex_valid=0, ex_aluop=00 (ALU control yields NOP), all controls 0, ex_dest=0.
- Latency: one cycle from ID inputs to EX register outputs. alu_x, alu_y, ex_store_data, load_use_o are same-cycle combinational.
- ex_dest is latched as id_regdst ? id_rd : id_rt.
- Update priority each edge: rst > flush_i > load_use_o > stall_i > normal load.
  - flush_i and load_use_o load a bubble: valid, all controls and aluop = 0, data fields don't-care.
  - stall_i holds every field, but rs_data/rt_data are rewritten with their forwarded values. This prevents a result retiring from MEM/WB during the stall from being lost.
  - Normal load takes all id_* fields.
- load_use_o = ex_valid & ex_memread & ex_dest != 0 & (ex_dest == id_rs | ex_dest == id_rt), gated by id_valid. It is forced to 0 when flush_i is high.
- Forwarding, applied per source operand (rs, rt):
  - Source index 0 always uses the stored value (reads 0).
  - EX/MEM is selected if exmem_regwrite and exmem_rd equals the index.
  - Else MEM/WB is selected if memwb_regwrite and memwb_rd equals the index.
  - Else the stored value is used.
  - When both match, EX/MEM wins.
- Operand select:
  - Shift (aluop=10, funct 000000/000010/000011): alu_x = fwd_rt, alu_y = zero-extended shamt.
  - Otherwise alu_x = fwd_rs, alu_y = alusrc ? imm : fwd_rt.
- ex_store_data = fwd_rt always.
- stall_i and flush_i high together: flush wins, bubble inserted.
- rst mid-stall: registers still cleared.

Decomposition:
- Shared package (mips_pkg):
  - opcode constants: LW, SW, ADDI, ANDI, ORI, XORI, SLTI
  - funct constants: ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA
  - ALUOp encodings: ALUOP_R=10, ALUOP_I=01, ALUOP_NONE=00
- One combinational sub-module, fwd_unit: inputs are the source index, stored data and both bypass ports; output is the forwarded value. Instantiated twice (rs, rt).

Test Plan:
- Reset then idle, rst=1 one edge -> ex_valid=0, ex_aluop=00, alu_x=alu_y=0, all controls 0.
- ADD $3,$1,$2 with rs_data=5, rt_data=7, no bypass -> next cycle alu_x=5, alu_y=7, ex_dest=3, ex_regwrite=1, ex_funct=100000.
- Double hazard: EX holds rs=1, exmem_rd=1 result=0xAA, memwb_rd=1 result=0xBB, both regwrite -> alu_x=0xAA. Drop exmem_regwrite -> alu_x=0xBB. Set rs=0 with exmem_rd=0 -> alu_x=0.
- Load-use: EX holds LW with dest 4, ID has rs=4 -> load_use_o=1 and the next edge loads a bubble (ex_valid=0). The following edge loads the dependent instruction normally.
- Stall refresh: EX holds rt=6 with stored 0 while memwb_rd=6, result 0x1234 and stall_i=1 for 2 cycles. memwb_regwrite drops after cycle 1 -> alu_y stays 0x1234.
- SRA $5,$2,3 with rt_data=0xF0 -> alu_x=0xF0, alu_y=3. Then flush_i=1 with stall_i=1 -> bubble, ex_regwrite=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, funct codes and ALUOp values.
// Pure definitions, no logic or latency.
// Imported by the ID/EX stage and its forwarding sub-unit.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;

   typedef enum logic [1:0] {
      ALUOP_NONE = 2'b00,
      ALUOP_I    = 2'b01,
      ALUOP_R    = 2'b10
   } aluop_e;

   // Shift-by-shamt instructions take the shifted value from rt, not rs.
   function automatic logic is_shamt_shift(input logic [1:0] aluop, input logic [5:0] funct);
      return (aluop == ALUOP_R) &&
             ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand bypass mux: picks EX/MEM, then MEM/WB, then the stored register value.
// Purely combinational, zero latency.
// No flow control; register 0 never bypasses so it always reads as stored (zero).
module fwd_unit #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic [RW-1:0] i_src_idx,
   input  logic [DW-1:0] i_stored_dat,
   input  logic          i_exmem_regwrite,
   input  logic [RW-1:0] i_exmem_rd,
   input  logic [DW-1:0] i_exmem_result,
   input  logic          i_memwb_regwrite,
   input  logic [RW-1:0] i_memwb_rd,
   input  logic [DW-1:0] i_memwb_result,
   output logic [DW-1:0] o_fwd_dat
);

   // Youngest producer wins; index 0 is hard-wired and never forwarded.
   always_comb begin
      o_fwd_dat = i_stored_dat;
      if (i_src_idx != '0) begin
         if (i_exmem_regwrite && (i_exmem_rd == i_src_idx))
            o_fwd_dat = i_exmem_result;
         else if (i_memwb_regwrite && (i_memwb_rd == i_src_idx))
            o_fwd_dat = i_memwb_result;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// One cycle ID->EX registers; ALU operands, store data and load_use_o are combinational.
// stall_i holds EX (refreshing forwarded data); flush_i or a load-use hazard loads a bubble.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          id_valid,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [4:0]    id_shamt,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [5:0]    id_opcode,
   input  logic [5:0]    id_funct,
   input  logic [1:0]    id_aluop,
   input  logic          id_alusrc,
   input  logic          id_regdst,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic          id_memtoreg,
   input  logic          exmem_regwrite,
   input  logic [RW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwrite,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_result,
   output logic          load_use_o,
   output logic          ex_valid,
   output logic [5:0]    ex_opcode,
   output logic [5:0]    ex_funct,
   output logic [1:0]    ex_aluop,
   output logic [DW-1:0] alu_x,
   output logic [DW-1:0] alu_y,
   output logic [DW-1:0] ex_store_data,
   output logic [RW-1:0] ex_dest,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          ex_memtoreg
);

   logic          r_valid;
   logic [DW-1:0] r_rs_data;
   logic [DW-1:0] r_rt_data;
   logic [DW-1:0] r_imm;
   logic [4:0]    r_shamt;
   logic [RW-1:0] r_rs;
   logic [RW-1:0] r_rt;
   logic [RW-1:0] r_dest;
   logic [5:0]    r_opcode;
   logic [5:0]    r_funct;
   logic [1:0]    r_aluop;
   logic          r_alusrc;
   logic          r_regwrite;
   logic          r_memread;
   logic          r_memwrite;
   logic          r_memtoreg;

   logic [DW-1:0] w_fwd_rs;
   logic [DW-1:0] w_fwd_rt;
   logic          w_load_use;

   fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rs (
      .i_src_idx        (r_rs),
      .i_stored_dat     (r_rs_data),
      .i_exmem_regwrite (exmem_regwrite),
      .i_exmem_rd       (exmem_rd),
      .i_exmem_result   (exmem_result),
      .i_memwb_regwrite (memwb_regwrite),
      .i_memwb_rd       (memwb_rd),
      .i_memwb_result   (memwb_result),
      .o_fwd_dat        (w_fwd_rs)
   );

   fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rt (
      .i_src_idx        (r_rt),
      .i_stored_dat     (r_rt_data),
      .i_exmem_regwrite (exmem_regwrite),
      .i_exmem_rd       (exmem_rd),
      .i_exmem_result   (exmem_result),
      .i_memwb_regwrite (memwb_regwrite),
      .i_memwb_rd       (memwb_rd),
      .i_memwb_result   (memwb_result),
      .o_fwd_dat        (w_fwd_rt)
   );

   // A load in EX whose destination is read by the instruction in ID cannot be bypassed in time.
   assign w_load_use = !flush_i && id_valid && r_valid && r_memread && (r_dest != '0) &&
                       ((r_dest == id_rs) || (r_dest == id_rt));
   assign load_use_o = w_load_use;

   // Shifts operate on rt by the immediate shift amount; everything else is rs op (imm|rt).
   always_comb begin
      alu_x = w_fwd_rs;
      alu_y = r_alusrc ? r_imm : w_fwd_rt;
      if (is_shamt_shift(r_aluop, r_funct)) begin
         alu_x = w_fwd_rt;
         alu_y = {{(DW-5){1'b0}}, r_shamt};
      end
   end

   assign ex_store_data = w_fwd_rt;
   assign ex_valid      = r_valid;
   assign ex_opcode     = r_opcode;
   assign ex_funct      = r_funct;
   assign ex_aluop      = r_aluop;
   assign ex_dest       = r_dest;
   assign ex_regwrite   = r_regwrite;
   assign ex_memread    = r_memread;
   assign ex_memwrite   = r_memwrite;
   assign ex_memtoreg   = r_memtoreg;

   // EX register update: reset > flush/load-use bubble > stall (refresh bypassed data) > load.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_rs_data  <= '0;
         r_rt_data  <= '0;
         r_imm      <= '0;
         r_shamt    <= '0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_dest     <= '0;
         r_opcode   <= '0;
         r_funct    <= '0;
         r_aluop    <= ALUOP_NONE;
         r_alusrc   <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_memtoreg <= 1'b0;
      end else if (flush_i || w_load_use) begin
         // Data fields are left as-is: a bubble has no side effects regardless of operands.
         r_valid    <= 1'b0;
         r_aluop    <= ALUOP_NONE;
         r_alusrc   <= 1'b0;
         r_regwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_memtoreg <= 1'b0;
      end else if (stall_i) begin
         // Capture bypassed values so a result retiring from MEM/WB mid-stall is not lost.
         r_rs_data  <= w_fwd_rs;
         r_rt_data  <= w_fwd_rt;
      end else begin
         r_valid    <= id_valid;
         r_rs_data  <= id_rs_data;
         r_rt_data  <= id_rt_data;
         r_imm      <= id_imm;
         r_shamt    <= id_shamt;
         r_rs       <= id_rs;
         r_rt       <= id_rt;
         r_dest     <= id_regdst ? id_rd : id_rt;
         r_opcode   <= id_opcode;
         r_funct    <= id_funct;
         r_aluop    <= id_aluop;
         r_alusrc   <= id_alusrc;
         r_regwrite <= id_regwrite;
         r_memread  <= id_memread;
         r_memwrite <= id_memwrite;
         r_memtoreg <= id_memtoreg;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX-stage results queued at drive time.
// Inputs change on the falling edge; outputs sampled 1 time unit after the rising edge.
// Combinational bypass checks are made mid-cycle while EX contents are stable.
module tb_id_ex_stage;
   import mips_pkg::*;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk;
   logic          rst;
   logic          stall_i;
   logic          flush_i;
   logic          id_valid;
   logic [DW-1:0] id_rs_data;
   logic [DW-1:0] id_rt_data;
   logic [DW-1:0] id_imm;
   logic [4:0]    id_shamt;
   logic [RW-1:0] id_rs;
   logic [RW-1:0] id_rt;
   logic [RW-1:0] id_rd;
   logic [5:0]    id_opcode;
   logic [5:0]    id_funct;
   logic [1:0]    id_aluop;
   logic          id_alusrc;
   logic          id_regdst;
   logic          id_regwrite;
   logic          id_memread;
   logic          id_memwrite;
   logic          id_memtoreg;
   logic          exmem_regwrite;
   logic [RW-1:0] exmem_rd;
   logic [DW-1:0] exmem_result;
   logic          memwb_regwrite;
   logic [RW-1:0] memwb_rd;
   logic [DW-1:0] memwb_result;
   logic          load_use_o;
   logic          ex_valid;
   logic [5:0]    ex_opcode;
   logic [5:0]    ex_funct;
   logic [1:0]    ex_aluop;
   logic [DW-1:0] alu_x;
   logic [DW-1:0] alu_y;
   logic [DW-1:0] ex_store_data;
   logic [RW-1:0] ex_dest;
   logic          ex_regwrite;
   logic          ex_memread;
   logic          ex_memwrite;
   logic          ex_memtoreg;

   typedef struct {
      logic          valid;
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic [RW-1:0] dest;
      logic          rw;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;

   id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .id_valid       (id_valid),
      .id_rs_data     (id_rs_data),
      .id_rt_data     (id_rt_data),
      .id_imm         (id_imm),
      .id_shamt       (id_shamt),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_rd          (id_rd),
      .id_opcode      (id_opcode),
      .id_funct       (id_funct),
      .id_aluop       (id_aluop),
      .id_alusrc      (id_alusrc),
      .id_regdst      (id_regdst),
      .id_regwrite    (id_regwrite),
      .id_memread     (id_memread),
      .id_memwrite    (id_memwrite),
      .id_memtoreg    (id_memtoreg),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .load_use_o     (load_use_o),
      .ex_valid       (ex_valid),
      .ex_opcode      (ex_opcode),
      .ex_funct       (ex_funct),
      .ex_aluop       (ex_aluop),
      .alu_x          (alu_x),
      .alu_y          (alu_y),
      .ex_store_data  (ex_store_data),
      .ex_dest        (ex_dest),
      .ex_regwrite    (ex_regwrite),
      .ex_memread     (ex_memread),
      .ex_memwrite    (ex_memwrite),
      .ex_memtoreg    (ex_memtoreg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      stall_i = 0; flush_i = 0; id_valid = 0;
      id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0;
      id_rs = '0; id_rt = '0; id_rd = '0; id_opcode = '0; id_funct = '0;
      id_aluop = ALUOP_NONE; id_alusrc = 0; id_regdst = 0; id_regwrite = 0;
      id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
      exmem_regwrite = 0; exmem_rd = '0; exmem_result = '0;
      memwb_regwrite = 0; memwb_rd = '0; memwb_result = '0;
   endtask

   // R-type instruction in ID: rd <- rs funct rt
   task automatic drive_rtype(input logic [5:0] fn, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                              input logic [RW-1:0] rd, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                              input logic [4:0] sh);
      id_valid = 1; id_opcode = OP_RTYPE; id_funct = fn; id_aluop = ALUOP_R;
      id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
      id_shamt = sh; id_imm = '0; id_alusrc = 0; id_regdst = 1; id_regwrite = 1;
      id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
   endtask

   // I-type instruction in ID: rt <- rs op imm (optionally a load)
   task automatic drive_itype(input logic [5:0] op, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                              input logic [DW-1:0] rsd, input logic [DW-1:0] imm, input logic ld);
      id_valid = 1; id_opcode = op; id_funct = '0; id_aluop = ld ? ALUOP_NONE : ALUOP_I;
      id_rs = rs; id_rt = rt; id_rd = '0; id_rs_data = rsd; id_rt_data = '0;
      id_shamt = '0; id_imm = imm; id_alusrc = 1; id_regdst = 0; id_regwrite = 1;
      id_memread = ld; id_memwrite = 0; id_memtoreg = ld;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1;
      @(posedge clk); #1;
      checks++; if (ex_valid !== 1'b0)    begin failures++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
      checks++; if (ex_aluop !== 2'b00)   begin failures++; $display("FAIL reset_aluop got=%0h exp=0", ex_aluop); end
      checks++; if (alu_x !== '0 || alu_y !== '0) begin failures++; $display("FAIL reset_operands got x=%0h y=%0h exp=0", alu_x, alu_y); end
      checks++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 4'b0)
         begin failures++; $display("FAIL reset_controls got=%b exp=0000", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}); end
      checks++; if (ex_dest !== '0)       begin failures++; $display("FAIL reset_dest got=%0d exp=0", ex_dest); end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_add();
      @(negedge clk);
      drive_rtype(FN_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 5'd0);
      sb.push_back('{valid: 1'b1, x: 32'd5, y: 32'd7, dest: 5'd3, rw: 1'b1});
      @(posedge clk); #1;
      if (sb.size() == 0) begin checks++; failures++; $display("FAIL add_sb got=empty exp=entry"); end
      else begin
         e = sb.pop_front();
         checks++; if (ex_valid !== e.valid) begin failures++; $display("FAIL add_valid got=%0h exp=%0h", ex_valid, e.valid); end
         checks++; if (alu_x !== e.x)        begin failures++; $display("FAIL add_x got=%0h exp=%0h", alu_x, e.x); end
         checks++; if (alu_y !== e.y)        begin failures++; $display("FAIL add_y got=%0h exp=%0h", alu_y, e.y); end
         checks++; if (ex_dest !== e.dest)   begin failures++; $display("FAIL add_dest got=%0d exp=%0d", ex_dest, e.dest); end
         checks++; if (ex_regwrite !== e.rw) begin failures++; $display("FAIL add_regwrite got=%0h exp=%0h", ex_regwrite, e.rw); end
      end
      checks++; if (ex_funct !== 6'b100000) begin failures++; $display("FAIL add_funct got=%b exp=100000", ex_funct); end
      checks++; if (ex_store_data !== 32'd7) begin failures++; $display("FAIL add_store got=%0h exp=7", ex_store_data); end
   endtask

   task automatic test_double_hazard();
      @(negedge clk);
      drive_rtype(FN_ADD, 5'd1, 5'd2, 5'd9, 32'h11, 32'h0, 5'd0);
      @(posedge clk); #1;
      exmem_regwrite = 1; exmem_rd = 5'd1; exmem_result = 32'hAA;
      memwb_regwrite = 1; memwb_rd = 5'd1; memwb_result = 32'hBB;
      sb.push_back('{valid: 1'b1, x: 32'hAA, y: 32'h0, dest: 5'd9, rw: 1'b1});
      #1;
      e = sb.pop_front();
      checks++; if (alu_x !== e.x) begin failures++; $display("FAIL dbl_exmem_wins got=%0h exp=%0h", alu_x, e.x); end
      exmem_regwrite = 0;
      sb.push_back('{valid: 1'b1, x: 32'hBB, y: 32'h0, dest: 5'd9, rw: 1'b1});
      #1;
      e = sb.pop_front();
      checks++; if (alu_x !== e.x) begin failures++; $display("FAIL dbl_memwb got=%0h exp=%0h", alu_x, e.x); end
      @(negedge clk);
      idle_inputs();
      drive_rtype(FN_ADD, 5'd0, 5'd2, 5'd9, 32'h0, 32'h0, 5'd0);
      @(posedge clk); #1;
      exmem_regwrite = 1; exmem_rd = 5'd0; exmem_result = 32'hCC;
      memwb_regwrite = 1; memwb_rd = 5'd0; memwb_result = 32'hDD;
      sb.push_back('{valid: 1'b1, x: 32'h0, y: 32'h0, dest: 5'd9, rw: 1'b1});
      #1;
      e = sb.pop_front();
      checks++; if (alu_x !== e.x) begin failures++; $display("FAIL dbl_r0_nofwd got=%0h exp=%0h", alu_x, e.x); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_load_use();
      @(negedge clk);
      drive_itype(OP_LW, 5'd1, 5'd4, 32'h100, 32'h8, 1'b1);
      @(posedge clk); #1;
      checks++; if (ex_memread !== 1'b1 || ex_memtoreg !== 1'b1 || ex_dest !== 5'd4)
         begin failures++; $display("FAIL lu_lw_latched got mr=%0h m2r=%0h dest=%0d exp 1 1 4", ex_memread, ex_memtoreg, ex_dest); end
      checks++; if (alu_x !== 32'h100 || alu_y !== 32'h8)
         begin failures++; $display("FAIL lu_lw_operands got x=%0h y=%0h exp x=100 y=8", alu_x, alu_y); end
      @(negedge clk);
      drive_rtype(FN_ADD, 5'd4, 5'd2, 5'd5, 32'h99, 32'h1, 5'd0);
      #1;
      checks++; if (load_use_o !== 1'b1) begin failures++; $display("FAIL lu_detect got=%0h exp=1", load_use_o); end
      flush_i = 1; #1;
      checks++; if (load_use_o !== 1'b0) begin failures++; $display("FAIL lu_flush_mask got=%0h exp=0", load_use_o); end
      flush_i = 0; id_valid = 0; #1;
      checks++; if (load_use_o !== 1'b0) begin failures++; $display("FAIL lu_idvalid_gate got=%0h exp=0", load_use_o); end
      id_valid = 1;
      sb.push_back('{valid: 1'b0, x: 32'h0, y: 32'h0, dest: 5'd0, rw: 1'b0});
      sb.push_back('{valid: 1'b1, x: 32'h99, y: 32'h1, dest: 5'd5, rw: 1'b1});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (ex_valid !== e.valid || ex_regwrite !== e.rw || ex_memread !== 1'b0)
         begin failures++; $display("FAIL lu_bubble got v=%0h rw=%0h mr=%0h exp 0 0 0", ex_valid, ex_regwrite, ex_memread); end
      checks++; if (load_use_o !== 1'b0) begin failures++; $display("FAIL lu_release got=%0h exp=0", load_use_o); end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (ex_valid !== e.valid || ex_dest !== e.dest || alu_x !== e.x || alu_y !== e.y)
         begin failures++; $display("FAIL lu_dependent got v=%0h d=%0d x=%0h y=%0h exp v=%0h d=%0d x=%0h y=%0h",
                                     ex_valid, ex_dest, alu_x, alu_y, e.valid, e.dest, e.x, e.y); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_stall_refresh();
      @(negedge clk);
      drive_rtype(FN_ADD, 5'd1, 5'd6, 5'd7, 32'h1, 32'h0, 5'd0);
      @(posedge clk); #1;
      @(negedge clk);
      drive_rtype(FN_SUB, 5'd2, 5'd3, 5'd12, 32'h55, 32'h66, 5'd0);
      stall_i = 1;
      memwb_regwrite = 1; memwb_rd = 5'd6; memwb_result = 32'h1234;
      for (int i = 0; i < 3; i++) sb.push_back('{valid: 1'b1, x: 32'h1, y: 32'h1234, dest: 5'd7, rw: 1'b1});
      #1;
      e = sb.pop_front();
      checks++; if (alu_y !== e.y) begin failures++; $display("FAIL stall_fwd got=%0h exp=%0h", alu_y, e.y); end
      @(posedge clk); #1;
      memwb_regwrite = 0;
      #1;
      e = sb.pop_front();
      checks++; if (alu_y !== e.y || ex_dest !== e.dest)
         begin failures++; $display("FAIL stall_cycle1 got y=%0h d=%0d exp y=%0h d=%0d", alu_y, ex_dest, e.y, e.dest); end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (alu_y !== e.y || ex_dest !== e.dest || alu_x !== e.x)
         begin failures++; $display("FAIL stall_cycle2 got x=%0h y=%0h d=%0d exp x=%0h y=%0h d=%0d", alu_x, alu_y, ex_dest, e.x, e.y, e.dest); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_sra_flush();
      @(negedge clk);
      drive_rtype(FN_SRA, 5'd0, 5'd2, 5'd5, 32'h0, 32'hF0, 5'd3);
      sb.push_back('{valid: 1'b1, x: 32'hF0, y: 32'd3, dest: 5'd5, rw: 1'b1});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (alu_x !== e.x || alu_y !== e.y || ex_dest !== e.dest)
         begin failures++; $display("FAIL sra_operands got x=%0h y=%0h d=%0d exp x=%0h y=%0h d=%0d", alu_x, alu_y, ex_dest, e.x, e.y, e.dest); end
      @(negedge clk);
      drive_rtype(FN_ADD, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 5'd0);
      stall_i = 1; flush_i = 1;
      sb.push_back('{valid: 1'b0, x: 32'h0, y: 32'h0, dest: 5'd0, rw: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (ex_valid !== e.valid || ex_regwrite !== e.rw || ex_aluop !== 2'b00)
         begin failures++; $display("FAIL flush_bubble got v=%0h rw=%0h aluop=%0h exp 0 0 0", ex_valid, ex_regwrite, ex_aluop); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      drive_itype(OP_ADDI, 5'd1, 5'd8, 32'h3, 32'h10, 1'b0);
      sb.push_back('{valid: 1'b1, x: 32'h3, y: 32'h10, dest: 5'd8, rw: 1'b1});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (alu_x !== e.x || alu_y !== e.y || ex_dest !== e.dest || ex_aluop !== 2'b01)
         begin failures++; $display("FAIL b2b_addi got x=%0h y=%0h d=%0d op=%0h exp x=%0h y=%0h d=%0d op=1", alu_x, alu_y, ex_dest, ex_aluop, e.x, e.y, e.dest); end
      @(negedge clk);
      drive_itype(OP_ORI, 5'd2, 5'd9, 32'h100, 32'hFF, 1'b0);
      sb.push_back('{valid: 1'b1, x: 32'h100, y: 32'hFF, dest: 5'd9, rw: 1'b1});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (alu_x !== e.x || alu_y !== e.y || ex_dest !== e.dest || ex_opcode !== OP_ORI)
         begin failures++; $display("FAIL b2b_ori got x=%0h y=%0h d=%0d opc=%b exp x=%0h y=%0h d=%0d", alu_x, alu_y, ex_dest, ex_opcode, e.x, e.y, e.dest); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_rst_mid_stall();
      @(negedge clk);
      drive_rtype(FN_OR, 5'd3, 5'd4, 5'd11, 32'h7, 32'h8, 5'd0);
      @(posedge clk); #1;
      @(negedge clk);
      stall_i = 1; rst = 1;
      @(posedge clk); #1;
      checks++; if (ex_valid !== 1'b0 || ex_dest !== '0 || ex_regwrite !== 1'b0 || alu_x !== '0)
         begin failures++; $display("FAIL rst_stall got v=%0h d=%0d rw=%0h x=%0h exp all 0", ex_valid, ex_dest, ex_regwrite, alu_x); end
      @(negedge clk);
      rst = 0;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_add();
      test_double_hazard();
      test_load_use();
      test_stall_refresh();
      test_sra_flush();
      test_back_to_back();
      test_rst_mid_stall();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
